// File: rtl/floppy_step_driver_pkg.sv
// Shared types and default sizing for the floppy step driver and its neighbours.
package floppy_step_driver_pkg;
  localparam int SP_W_DEF         = 22;
  localparam int MAX_TRACK_DEF    = 79;
  localparam int PULSE_CYCLES_DEF = 50;
  localparam int HOME_PERIOD_DEF  = 150000;
  localparam int TRACK_W          = 7;

  typedef enum logic [1:0] {
    ST_HOME = 2'd0,
    ST_IDLE = 2'd1,
    ST_PLAY = 2'd2
  } state_t;
endpackage

// File: rtl/floppy_step_pulse.sv
// One-shot STEP generator: a 1-cycle fire gives a PULSE_CYCLES-wide low pulse starting the next cycle.
// start is high on the first low cycle, done on the first high cycle after the pulse; fire is ignored mid-pulse.
module floppy_step_pulse #(
  parameter int PULSE_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic step_n,
  output logic start,
  output logic done
);
  localparam int PW = (PULSE_CYCLES > 0) ? $clog2(PULSE_CYCLES + 1) : 1;

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_n <= 1'b1;
      start  <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      if (!step_n) begin
        if (cnt == PW'(1)) begin
          step_n <= 1'b1;
          done   <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt - PW'(1);
        end
      end else if (fire) begin
        step_n <= 1'b0;
        start  <= 1'b1;
        cnt    <= PW'(PULSE_CYCLES);
      end
    end
  end
endmodule

// File: rtl/floppy_step_driver.sv
// Drives one floppy's STEP/DIR/SELECT to play a tone: homes to track 0, then sweeps the head
// stepping once per setpoint cycles (clamped so every pulse has room to finish). All pins registered.
module floppy_step_driver
  import floppy_step_driver_pkg::*;
#(
  parameter int SP_W         = SP_W_DEF,
  parameter int MAX_TRACK    = MAX_TRACK_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int HOME_PERIOD  = HOME_PERIOD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SP_W-1:0]    setpoint,
  input  logic               en,
  output logic               step_n,
  output logic               dir,
  output logic               sel_n,
  output logic               homed,
  output logic [TRACK_W-1:0] track
);
  localparam int HOME_W = (HOME_PERIOD > 1) ? $clog2(HOME_PERIOD) : 1;
  localparam int HN_W   = $clog2(MAX_TRACK + 2);
  localparam logic [SP_W-1:0]    P_MIN       = SP_W'(2 * PULSE_CYCLES);
  localparam logic [HOME_W-1:0]  HOME_LAST   = HOME_W'(HOME_PERIOD - 1);
  localparam logic [HN_W-1:0]    HOME_PULSES = HN_W'(MAX_TRACK + 1);
  localparam logic [TRACK_W-1:0] TRACK_MAX   = TRACK_W'(MAX_TRACK);

  state_t              state;
  logic [SP_W-1:0]     per_cnt;
  logic [SP_W-1:0]     per_len;
  logic [HOME_W-1:0]   home_cnt;
  logic [HN_W-1:0]     home_n;
  logic                fire;
  logic                pulse_start;
  logic                pulse_done;
  logic                play_req;
  logic [SP_W-1:0]     next_len;

  assign play_req = en && (setpoint != '0);
  assign next_len = (setpoint < P_MIN) ? P_MIN : setpoint;

  always_comb begin
    fire = 1'b0;
    case (state)
      ST_HOME: fire = (home_cnt == HOME_LAST) && (home_n != HOME_PULSES);
      ST_PLAY: fire = (per_cnt == per_len - SP_W'(1));
      default: fire = 1'b0;
    endcase
  end

  floppy_step_pulse #(
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .fire  (fire),
    .step_n(step_n),
    .start (pulse_start),
    .done  (pulse_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HOME;
      dir      <= 1'b0;
      sel_n    <= 1'b0;
      homed    <= 1'b0;
      track    <= '0;
      per_cnt  <= '0;
      per_len  <= '0;
      home_cnt <= '0;
      home_n   <= '0;
    end else begin
      case (state)
        ST_HOME: begin
          if (home_n != HOME_PULSES)
            home_cnt <= (home_cnt == HOME_LAST) ? '0 : home_cnt + HOME_W'(1);
          if (fire)
            home_n <= home_n + HN_W'(1);
          // Head position is unknown until the full sweep toward track 0 has been issued.
          if (pulse_done && (home_n == HOME_PULSES)) begin
            state    <= ST_IDLE;
            dir      <= 1'b1;
            homed    <= 1'b1;
            sel_n    <= 1'b1;
            track    <= '0;
            home_cnt <= '0;
            home_n   <= '0;
          end
        end
        ST_IDLE: begin
          per_cnt <= '0;
          if (play_req) begin
            state   <= ST_PLAY;
            sel_n   <= 1'b0;
            per_len <= next_len;
          end
        end
        ST_PLAY: begin
          if (pulse_start)
            track <= dir ? track + TRACK_W'(1) : track - TRACK_W'(1);
          // Direction only flips once the pulse is over so DIR never moves under a low STEP.
          if (pulse_done) begin
            if (track == TRACK_MAX)
              dir <= 1'b0;
            else if (track == '0)
              dir <= 1'b1;
          end
          if (fire) begin
            per_cnt <= '0;
            per_len <= next_len;
          end else if (!play_req && step_n) begin
            state   <= ST_IDLE;
            sel_n   <= 1'b1;
            per_cnt <= '0;
          end else begin
            per_cnt <= per_cnt + SP_W'(1);
          end
        end
        default: begin
          state <= ST_HOME;
          sel_n <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_floppy_step_driver.sv
// Directed bench for floppy_step_driver with small sim parameters (MAX_TRACK=3, PULSE_CYCLES=2, HOME_PERIOD=10).
module tb_floppy_step_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] setpoint = '0;
  logic        en = 1'b0;
  logic        step_n;
  logic        dir;
  logic        sel_n;
  logic        homed;
  logic [6:0]  track;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  floppy_step_driver #(
    .SP_W(22),
    .MAX_TRACK(3),
    .PULSE_CYCLES(2),
    .HOME_PERIOD(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .setpoint(setpoint),
    .en(en),
    .step_n(step_n),
    .dir(dir),
    .sel_n(sel_n),
    .homed(homed),
    .track(track)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next high-to-low STEP edge; lows counts low samples before it, including the start sample.
  task automatic wait_fall(input int budget, output int n, output int lows);
    logic prev;
    n = 0;
    lows = (step_n == 1'b0) ? 1 : 0;
    prev = step_n;
    while (n < budget) begin
      tick;
      n++;
      if (prev && !step_n) break;
      if (!step_n) lows++;
      prev = step_n;
    end
  endtask

  task automatic count_low(input int budget, output int n);
    n = 0;
    while (!step_n && n < budget) begin
      tick;
      n++;
    end
  endtask

  task automatic count_falls(input int ncyc, output int falls);
    logic prev;
    falls = 0;
    prev = step_n;
    for (int i = 0; i < ncyc; i++) begin
      tick;
      if (prev && !step_n) falls++;
      prev = step_n;
    end
  endtask

  task automatic home_seq(input string tag);
    int n, l;
    wait_fall(40, n, l);
    checks++; if (n !== 10) begin failures++; $display("FAIL %s_first_pulse got=%0d exp=10", tag, n); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL %s_dir got=%0b exp=0", tag, dir); end
    checks++; if (sel_n !== 1'b0) begin failures++; $display("FAIL %s_sel_n got=%0b exp=0", tag, sel_n); end
    for (int k = 1; k < 4; k++) begin
      wait_fall(40, n, l);
      checks++; if (n !== 10) begin failures++; $display("FAIL %s_spacing%0d got=%0d exp=10", tag, k, n); end
      checks++; if (l !== 2) begin failures++; $display("FAIL %s_width%0d got=%0d exp=2", tag, k, l); end
      checks++; if (dir !== 1'b0) begin failures++; $display("FAIL %s_dir%0d got=%0b exp=0", tag, k, dir); end
    end
    count_low(10, n);
    checks++; if (n !== 2) begin failures++; $display("FAIL %s_last_width got=%0d exp=2", tag, n); end
    n = 0;
    while (!homed && n < 10) begin
      tick;
      n++;
    end
    checks++; if (n !== 1 || homed !== 1'b1) begin failures++; $display("FAIL %s_homed got=%0b after %0d exp=1 after 1", tag, homed, n); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL %s_dir_after got=%0b exp=1", tag, dir); end
    checks++; if (track !== 7'd0) begin failures++; $display("FAIL %s_track_after got=%0d exp=0", tag, track); end
    checks++; if (sel_n !== 1'b1) begin failures++; $display("FAIL %s_sel_after got=%0b exp=1", tag, sel_n); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++; if (step_n !== 1'b1) begin failures++; $display("FAIL rst_step_n got=%0b exp=1", step_n); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL rst_dir got=%0b exp=0", dir); end
    checks++; if (sel_n !== 1'b0) begin failures++; $display("FAIL rst_sel_n got=%0b exp=0", sel_n); end
    checks++; if (homed !== 1'b0) begin failures++; $display("FAIL rst_homed got=%0b exp=0", homed); end
    checks++; if (track !== 7'd0) begin failures++; $display("FAIL rst_track got=%0d exp=0", track); end
  endtask

  task automatic test_homing;
    int f;
    rst = 1'b0;
    home_seq("home");
    count_falls(30, f);
    checks++; if (f !== 0) begin failures++; $display("FAIL idle_no_pulse got=%0d exp=0", f); end
    checks++; if (sel_n !== 1'b1) begin failures++; $display("FAIL idle_sel_n got=%0b exp=1", sel_n); end
  endtask

  task automatic test_play;
    int n, l;
    int exp_track[6] = '{0, 1, 2, 3, 2, 1};
    int exp_dir[6] = '{1, 1, 1, 0, 0, 0};
    en = 1'b1;
    setpoint = 22'd20;
    n = 0;
    while (sel_n !== 1'b0 && n < 5) begin
      tick;
      n++;
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL play_entry got=%0d exp=1", n); end
    for (int i = 0; i < 6; i++) begin
      wait_fall(40, n, l);
      checks++; if (n !== 20) begin failures++; $display("FAIL play_period%0d got=%0d exp=20", i, n); end
      if (i > 0) begin
        checks++; if (l !== 2) begin failures++; $display("FAIL play_width%0d got=%0d exp=2", i, l); end
      end
      checks++; if (track !== 7'(exp_track[i])) begin failures++; $display("FAIL play_track%0d got=%0d exp=%0d", i, track, exp_track[i]); end
      checks++; if (dir !== 1'(exp_dir[i])) begin failures++; $display("FAIL play_dir%0d got=%0b exp=%0d", i, dir, exp_dir[i]); end
    end
    tick;
    checks++; if (track !== 7'd0) begin failures++; $display("FAIL play_track_end got=%0d exp=0", track); end
    repeat (4) tick;
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL play_dir_end got=%0b exp=1", dir); end
  endtask

  task automatic test_setpoint_change;
    int n, l;
    wait_fall(40, n, l);
    checks++; if (n !== 15) begin failures++; $display("FAIL sp_sync got=%0d exp=15", n); end
    repeat (5) tick;
    setpoint = 22'd30;
    wait_fall(40, n, l);
    checks++; if (n !== 15) begin failures++; $display("FAIL sp_old_period got=%0d exp=15", n); end
    wait_fall(60, n, l);
    checks++; if (n !== 30) begin failures++; $display("FAIL sp_new_period got=%0d exp=30", n); end
  endtask

  task automatic test_en_drop;
    int n, l, f;
    en = 1'b0;
    count_low(10, n);
    checks++; if (n !== 2) begin failures++; $display("FAIL drop_width got=%0d exp=2", n); end
    tick;
    checks++; if (sel_n !== 1'b1) begin failures++; $display("FAIL drop_sel_n got=%0b exp=1", sel_n); end
    checks++; if (track !== 7'd3) begin failures++; $display("FAIL drop_track got=%0d exp=3", track); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL drop_dir got=%0b exp=0", dir); end
    count_falls(40, f);
    checks++; if (f !== 0) begin failures++; $display("FAIL drop_no_pulse got=%0d exp=0", f); end
    checks++; if (track !== 7'd3) begin failures++; $display("FAIL drop_track_hold got=%0d exp=3", track); end
    en = 1'b1;
    setpoint = 22'd20;
    wait_fall(40, n, l);
    checks++; if (n !== 21) begin failures++; $display("FAIL resume_first got=%0d exp=21", n); end
    tick;
    checks++; if (track !== 7'd2) begin failures++; $display("FAIL resume_track got=%0d exp=2", track); end
  endtask

  task automatic test_clamp;
    int n, l, f;
    setpoint = 22'd1;
    wait_fall(40, n, l);
    checks++; if (n !== 19) begin failures++; $display("FAIL clamp_prev_period got=%0d exp=19", n); end
    wait_fall(20, n, l);
    checks++; if (n !== 4) begin failures++; $display("FAIL clamp_period1 got=%0d exp=4", n); end
    checks++; if (l !== 2) begin failures++; $display("FAIL clamp_width got=%0d exp=2", l); end
    wait_fall(20, n, l);
    checks++; if (n !== 4) begin failures++; $display("FAIL clamp_period2 got=%0d exp=4", n); end
    setpoint = 22'd0;
    count_low(10, n);
    tick;
    checks++; if (sel_n !== 1'b1) begin failures++; $display("FAIL zero_sp_sel_n got=%0b exp=1", sel_n); end
    count_falls(40, f);
    checks++; if (f !== 0) begin failures++; $display("FAIL zero_sp_no_pulse got=%0d exp=0", f); end
  endtask

  task automatic test_reset_midpulse;
    int n, l;
    setpoint = 22'd20;
    wait_fall(40, n, l);
    checks++; if (n !== 21) begin failures++; $display("FAIL mid_first got=%0d exp=21", n); end
    tick;
    checks++; if (step_n !== 1'b0) begin failures++; $display("FAIL mid_still_low got=%0b exp=0", step_n); end
    rst = 1'b1;
    #1;
    checks++; if (step_n !== 1'b1) begin failures++; $display("FAIL mid_rst_step_n got=%0b exp=1", step_n); end
    checks++; if (homed !== 1'b0) begin failures++; $display("FAIL mid_rst_homed got=%0b exp=0", homed); end
    checks++; if (track !== 7'd0) begin failures++; $display("FAIL mid_rst_track got=%0d exp=0", track); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL mid_rst_dir got=%0b exp=0", dir); end
    checks++; if (sel_n !== 1'b0) begin failures++; $display("FAIL mid_rst_sel_n got=%0b exp=0", sel_n); end
    repeat (2) tick;
    rst = 1'b0;
    home_seq("rehome");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_homing();
    test_play();
    test_setpoint_change();
    test_en_drop();
    test_clamp();
    test_reset_midpulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
